// File: rtl/table_phaseerrors_arbiter_pkg.sv
// Shared widths and packed types for the phase-error table and its arbiter.
package pam_table_pkg;
  localparam int ANGLE_W     = 9;
  localparam int PHASE_W     = 9;
  localparam int PHI_ERR_W   = 9;
  localparam int VAL_ENGLE_W = 10;
  localparam int TBL_ADDR_W  = PHASE_W + ANGLE_W;

  // Table address layout: {phase_acum_mod, input_angles}
  typedef struct packed {
    logic [PHASE_W-1:0] phase;
    logic [ANGLE_W-1:0] angle;
  } tbl_addr_t;
endpackage

// File: rtl/table_phaseerrors_arbiter_if.sv
// Channel-side and table-side bus of the phase-error table arbiter.
interface table_phaseerrors_arbiter_if
  import pam_table_pkg::*;
#(parameter int N_CH = 4);
  logic                          hold;
  logic [N_CH-1:0]               req;
  logic [N_CH*ANGLE_W-1:0]       req_angle;
  logic [N_CH*PHASE_W-1:0]       req_phase;
  logic [N_CH-1:0]               gnt;
  logic [ANGLE_W-1:0]            tbl_input_angles;
  logic [PHASE_W-1:0]            tbl_phase_acum_mod;
  logic [PHI_ERR_W-1:0]          tbl_phi_error;
  logic [VAL_ENGLE_W-1:0]        tbl_val_engle;
  logic [N_CH-1:0]               rsp_valid;
  logic [N_CH*PHI_ERR_W-1:0]     rsp_phi_error;
  logic [N_CH*VAL_ENGLE_W-1:0]   rsp_val_engle;

  modport slave (
    input  hold, req, req_angle, req_phase, tbl_phi_error, tbl_val_engle,
    output gnt, tbl_input_angles, tbl_phase_acum_mod,
           rsp_valid, rsp_phi_error, rsp_val_engle
  );

  modport master (
    output hold, req, req_angle, req_phase, tbl_phi_error, tbl_val_engle,
    input  gnt, tbl_input_angles, tbl_phase_acum_mod,
           rsp_valid, rsp_phi_error, rsp_val_engle
  );
endinterface

// File: rtl/table_phaseerrors_arbiter_rr_arbiter.sv
// Round-robin priority picker: first requester at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  logic [IW:0] pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      // ptr_i < N, so one conditional subtract is enough for the modulo
      pos = {1'b0, ptr_i} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      if (!any_o && req_i[pos[IW-1:0]]) begin
        any_o                 = 1'b1;
        gnt_o[pos[IW-1:0]]    = 1'b1;
        idx_o                 = pos[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/table_phaseerrors_arbiter.sv
// Shares one registered phase-error table among N_CH channels: round-robin
// grant, tag tracking through the table latency, per-channel result demux.
module table_phaseerrors_arbiter
  import pam_table_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int TABLE_LAT = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  table_phaseerrors_arbiter_if.slave  bus
);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [IDX_W-1:0]                       rr_ptr_q, rr_ptr_d, win_idx;
  logic [N_CH-1:0]                        arb_gnt;
  logic                                   arb_any, grant;
  tbl_addr_t                              addr_q, win_addr;
  logic [TABLE_LAT-1:0]                   vld_pipe_q;
  logic [TABLE_LAT-1:0][IDX_W-1:0]        idx_pipe_q;
  logic [IDX_W-1:0]                       rsp_idx;
  logic [N_CH-1:0]                        rsp_valid_q;
  logic [N_CH-1:0][PHI_ERR_W-1:0]         rsp_phi_q;
  logic [N_CH-1:0][VAL_ENGLE_W-1:0]       rsp_val_q;

  rr_arbiter #(.N(N_CH), .IW(IDX_W)) u_rr (
    .req_i (bus.req & {N_CH{~bus.hold}}),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (win_idx),
    .any_o (arb_any)
  );

  assign grant   = arb_any & reset_n;
  assign bus.gnt = arb_gnt & {N_CH{reset_n}};

  assign win_addr.phase = bus.req_phase[win_idx*PHASE_W +: PHASE_W];
  assign win_addr.angle = bus.req_angle[win_idx*ANGLE_W +: ANGLE_W];

  // Idle cycles replay the last winner so the table address stays quiet
  assign {bus.tbl_phase_acum_mod, bus.tbl_input_angles} = grant ? win_addr : addr_q;

  assign rr_ptr_d = (win_idx == IDX_W'(N_CH-1)) ? '0 : win_idx + 1'b1;
  assign rsp_idx  = idx_pipe_q[TABLE_LAT-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q    <= '0;
      addr_q      <= '0;
      vld_pipe_q  <= '0;
      idx_pipe_q  <= '0;
      rsp_valid_q <= '0;
      rsp_phi_q   <= '0;
      rsp_val_q   <= '0;
    end else begin
      if (grant) begin
        rr_ptr_q <= rr_ptr_d;
        addr_q   <= win_addr;
      end
      vld_pipe_q[0] <= grant;
      idx_pipe_q[0] <= win_idx;
      for (int s = 1; s < TABLE_LAT; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        idx_pipe_q[s] <= idx_pipe_q[s-1];
      end
      rsp_valid_q <= '0;
      if (vld_pipe_q[TABLE_LAT-1]) begin
        rsp_valid_q[rsp_idx] <= 1'b1;
        rsp_phi_q[rsp_idx]   <= bus.tbl_phi_error;
        rsp_val_q[rsp_idx]   <= bus.tbl_val_engle;
      end
    end
  end

  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_phi_error = rsp_phi_q;
  assign bus.rsp_val_engle = rsp_val_q;
endmodule
